// File: rtl/mem_responder.sv
// mem_responder: word memory behind a req/ack handshake with WAIT_CYCLES wait states.
// Define MEM_RESP_ERR_EN to reject misaligned or out-of-range addresses with err_o.
module mem_responder #(
  parameter int DEPTH = 128,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        ready_o,
  output logic        ack_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic we_q, err_q, accept, commit, c_we, bad;
  logic [31:0] addr_q, wdata_q, c_addr, c_wdata;
  logic [AW-1:0] idx;
  logic [31:0] mem [DEPTH];
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    if (state == IDLE && req_i) begin
      state_nx = WAIT_CYCLES > 0 ? WAIT : RESP;
      cnt_nx = WAIT_CYCLES > 0 ? 4'(WAIT_CYCLES - 1) : 4'd0;
    end else if (state == WAIT) begin
      state_nx = cnt == 4'd0 ? RESP : WAIT;
      cnt_nx = cnt == 4'd0 ? cnt : cnt - 4'd1;
    end else if (state != IDLE) state_nx = IDLE;
  end
  assign accept = state == IDLE && req_i;
  assign commit = state_nx == RESP;
  // With zero wait states the commit happens on the accepting edge, so take the live inputs.
  assign c_we = state == IDLE ? we_i : we_q;
  assign c_addr = state == IDLE ? addr_i : addr_q;
  assign c_wdata = state == IDLE ? wdata_i : wdata_q;
  assign idx = c_addr[AW+1:2];
`ifdef MEM_RESP_ERR_EN
  assign bad = c_addr[1:0] != 2'b00 || {2'b00, c_addr[31:2]} >= 32'(DEPTH);
`else
  logic unused_addr;
  assign unused_addr = ^{c_addr[31:AW+2], c_addr[1:0]};
  assign bad = 1'b0;
`endif
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt <= 4'd0;
      rdata_o <= 32'd0;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      if (accept) begin
        we_q <= we_i;
        addr_q <= addr_i;
        wdata_q <= wdata_i;
      end
      if (commit) begin
        err_q <= bad;
        if (!c_we && !bad) rdata_o <= mem[idx];
      end
    end
  end
  always_ff @(posedge clk_i)
    if (!rst_i && commit && c_we && !bad) mem[idx] <= c_wdata;
  assign ready_o = state == IDLE;
  assign ack_o = state == RESP;
  assign err_o = ack_o & err_q;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized checks of mem_responder against an array model (WAIT_CYCLES 2 and 0).
module tb_mem_responder;
  localparam int DEPTH = 128;
  localparam int W = 2;
  logic clk = 0, rst = 1, req = 0, we = 0, req0 = 0, we0 = 0;
  logic [31:0] addr = 0, wdata = 0, addr0 = 0, wdata0 = 0;
  logic ready, ack, err, ready0, ack0, err0;
  logic [31:0] rdata, rdata0;
  logic [31:0] model [DEPTH];
  logic [31:0] rd_model = 0;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .ready_o(ready), .ack_o(ack), .rdata_o(rdata), .err_o(err));
  mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .req_i(req0), .we_i(we0), .addr_i(addr0), .wdata_i(wdata0),
    .ready_o(ready0), .ack_o(ack0), .rdata_o(rdata0), .err_o(err0));

  function automatic void model_access(input logic w, input logic [31:0] a, d, output logic e);
    logic [29:0] wi;
    int i;
    wi = a[31:2];
`ifdef MEM_RESP_ERR_EN
    e = a[1:0] != 2'b00 || wi >= 30'(DEPTH);
`else
    e = 1'b0;
`endif
    i = int'(wi % 30'(DEPTH));
    if (!e) begin
      if (w) model[i] = d;
      else rd_model = model[i];
    end
  endfunction

  // Drives one request after an edge; lat counts edges from that drive edge to the first ack.
  task automatic access(input logic w, input logic [31:0] a, d, output int lat, output logic e, output logic [31:0] rd);
    @(posedge clk); #1;
    req = 1; we = w; addr = a; wdata = d;
    @(posedge clk); #1;
    req = 0; we = 1'($urandom); addr = $urandom; wdata = $urandom;
    lat = 1;
    while (ack !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    e = err; rd = rdata;
  endtask

  task automatic test_reset();
    rst = 1; req = 1; req0 = 1;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (ready !== 1'b1 || ack !== 1'b0 || err !== 1'b0 || rdata !== 32'd0) begin
      fails++; $display("FAIL reset: ready/ack/err/rdata=%b %b %b %h want 1 0 0 00000000", ready, ack, err, rdata);
    end
    tests++;
    if (ready0 !== 1'b1 || ack0 !== 1'b0 || err0 !== 1'b0 || rdata0 !== 32'd0) begin
      fails++; $display("FAIL reset0: ready/ack/err/rdata=%b %b %b %h want 1 0 0 00000000", ready0, ack0, err0, rdata0);
    end
    req = 0; req0 = 0; rst = 0;
    @(posedge clk); #1;
    tests++;
    if (ready !== 1'b1 || ack !== 1'b0) begin
      fails++; $display("FAIL reset_release: ready=%b ack=%b want 1 0", ready, ack);
    end
  endtask

  task automatic test_fill();
    int lat; logic e, ee; logic [31:0] rd, d;
    for (int i = 0; i < DEPTH; i++) begin
      d = $urandom;
      model_access(1'b1, 32'(i) << 2, d, ee);
      access(1'b1, 32'(i) << 2, d, lat, e, rd);
      tests++;
      if (lat !== W + 1 || e !== ee || rd !== rd_model) begin
        fails++; $display("FAIL fill[%0d]: lat=%0d err=%b rdata=%h want %0d %b %h", i, lat, e, rd, W + 1, ee, rd_model);
      end
    end
  endtask

  task automatic test_scenario1();
    int lat; logic e; logic [31:0] rd;
    access(1'b1, 32'h10, 32'hDEADBEEF, lat, e, rd);
    model[4] = 32'hDEADBEEF;
    tests++;
    if (lat !== 3 || e !== 1'b0) begin
      fails++; $display("FAIL scen1_write: lat=%0d err=%b want 3 0", lat, e);
    end
    access(1'b0, 32'h10, 32'h0, lat, e, rd);
    rd_model = 32'hDEADBEEF;
    tests++;
    if (lat !== 3 || e !== 1'b0 || rd !== 32'hDEADBEEF) begin
      fails++; $display("FAIL scen1_read: lat=%0d err=%b rdata=%h want 3 0 deadbeef", lat, e, rd);
    end
  endtask

  task automatic test_err();
    int lat; logic e, ee; logic [31:0] rd;
    model_access(1'b0, 32'h14, 32'h0, ee);
    access(1'b0, 32'h14, 32'h0, lat, e, rd);
    tests++;
    if (lat !== W + 1 || e !== ee || rd !== rd_model) begin
      fails++; $display("FAIL read14: lat=%0d err=%b rdata=%h want %0d %b %h", lat, e, rd, W + 1, ee, rd_model);
    end
    model_access(1'b0, 32'h13, 32'h0, ee);
    access(1'b0, 32'h13, 32'h0, lat, e, rd);
    tests++;
`ifdef MEM_RESP_ERR_EN
    if (e !== 1'b1 || rd !== rd_model) begin
      fails++; $display("FAIL misaligned: err=%b rdata=%h want 1 %h", e, rd, rd_model);
    end
`else
    if (e !== 1'b0 || rd !== 32'hDEADBEEF) begin
      fails++; $display("FAIL misaligned: err=%b rdata=%h want 0 deadbeef", e, rd);
    end
`endif
  endtask

  task automatic test_wrap();
    int lat; logic e, ee; logic [31:0] rd;
    model_access(1'b1, 32'h0, 32'h11111111, ee);
    access(1'b1, 32'h0, 32'h11111111, lat, e, rd);
    tests++;
    if (e !== 1'b0) begin
      fails++; $display("FAIL wrap_w0: err=%b want 0", e);
    end
    model_access(1'b1, 32'h200, 32'h22222222, ee);
    access(1'b1, 32'h200, 32'h22222222, lat, e, rd);
    model_access(1'b0, 32'h0, 32'h0, ee);
    tests++;
`ifdef MEM_RESP_ERR_EN
    if (e !== 1'b1) begin
      fails++; $display("FAIL wrap_w200: err=%b want 1", e);
    end
    access(1'b0, 32'h0, 32'h0, lat, e, rd);
    tests++;
    if (e !== 1'b0 || rd !== 32'h11111111) begin
      fails++; $display("FAIL wrap_r0: err=%b rdata=%h want 0 11111111", e, rd);
    end
`else
    if (e !== 1'b0) begin
      fails++; $display("FAIL wrap_w200: err=%b want 0", e);
    end
    access(1'b0, 32'h0, 32'h0, lat, e, rd);
    tests++;
    if (e !== 1'b0 || rd !== 32'h22222222) begin
      fails++; $display("FAIL wrap_r0: err=%b rdata=%h want 0 22222222", e, rd);
    end
`endif
  endtask

  task automatic test_random();
    int lat; logic e, ee, w; logic [31:0] rd, a, d;
    for (int n = 0; n < 80; n++) begin
      w = 1'($urandom);
      a = $urandom_range(0, 3) == 0 ? $urandom_range(0, DEPTH * 8 - 1) : 32'($urandom_range(0, DEPTH - 1)) << 2;
      d = $urandom;
      model_access(w, a, d, ee);
      access(w, a, d, lat, e, rd);
      tests++;
      if (lat !== W + 1 || e !== ee || rd !== rd_model) begin
        fails++; $display("FAIL random[%0d] we=%b addr=%h: lat=%0d err=%b rdata=%h want %0d %b %h", n, w, a, lat, e, rd, W + 1, ee, rd_model);
      end
      @(posedge clk); #1;
      tests++;
      if (ack !== 1'b0 || err !== 1'b0) begin
        fails++; $display("FAIL ack_pulse[%0d]: ack=%b err=%b want 0 0", n, ack, err);
      end
    end
  endtask

  task automatic test_back_to_back();
    int acks, accepts; logic [31:0] a;
    a = 32'($urandom_range(0, DEPTH - 1)) << 2;
    acks = 0; accepts = 0;
    @(posedge clk); #1;
    req = 1; we = 0; addr = a;
    for (int k = 0; k < 12; k++) begin
      tests++;
      if (ready !== (k % 4 == 0) || ack !== (k % 4 == 3)) begin
        fails++; $display("FAIL b2b cycle %0d: ready=%b ack=%b want %b %b", k, ready, ack, k % 4 == 0, k % 4 == 3);
      end
      if (ready === 1'b1) accepts++;
      if (ack === 1'b1) begin
        acks++;
        tests++;
        if (rdata !== model[a >> 2]) begin
          fails++; $display("FAIL b2b_rdata: got %h want %h", rdata, model[a >> 2]);
        end
      end
      @(posedge clk); #1;
    end
    req = 0;
    rd_model = model[a >> 2];
    tests++;
    if (accepts !== 3 || acks !== 3) begin
      fails++; $display("FAIL b2b_count: accepts=%0d acks=%0d want 3 3", accepts, acks);
    end
  endtask

  task automatic test_reset_abort();
    int lat, acks; logic e; logic [31:0] rd, old;
    old = model[8];
    @(posedge clk); #1;
    req = 1; we = 1; addr = 32'h20; wdata = 32'h5A5A5A5A;
    @(posedge clk); #1;
    req = 0;
    tests++;
    if (ready !== 1'b0) begin
      fails++; $display("FAIL abort_wait: ready=%b want 0", ready);
    end
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    rd_model = 32'd0;
    tests++;
    if (ack !== 1'b0 || rdata !== 32'd0 || ready !== 1'b1) begin
      fails++; $display("FAIL abort_reset: ack=%b rdata=%h ready=%b want 0 00000000 1", ack, rdata, ready);
    end
    acks = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (ack === 1'b1) acks++;
      if (k == 0) begin
        tests++;
        if (ready !== 1'b1) begin
          fails++; $display("FAIL abort_ready: ready=%b want 1", ready);
        end
      end
    end
    tests++;
    if (acks !== 0) begin
      fails++; $display("FAIL abort_noack: acks=%0d want 0", acks);
    end
    access(1'b0, 32'h20, 32'h0, lat, e, rd);
    rd_model = old;
    tests++;
    if (e !== 1'b0 || rd !== old) begin
      fails++; $display("FAIL abort_read: err=%b rdata=%h want 0 %h", e, rd, old);
    end
  endtask

  task automatic test_zero_wait();
    int acks; logic [31:0] v;
    v = $urandom;
    @(posedge clk); #1;
    req0 = 1; we0 = 1; addr0 = 32'h8; wdata0 = v;
    @(posedge clk); #1;
    req0 = 0; wdata0 = $urandom;
    tests++;
    if (ack0 !== 1'b1 || err0 !== 1'b0) begin
      fails++; $display("FAIL zw_write: ack=%b err=%b want 1 0", ack0, err0);
    end
    @(posedge clk); #1;
    tests++;
    if (ack0 !== 1'b0 || ready0 !== 1'b1) begin
      fails++; $display("FAIL zw_idle: ack=%b ready=%b want 0 1", ack0, ready0);
    end
    req0 = 1; we0 = 0; addr0 = 32'h8;
    @(posedge clk); #1;
    req0 = 0;
    tests++;
    if (ack0 !== 1'b1 || rdata0 !== v) begin
      fails++; $display("FAIL zw_read: ack=%b rdata=%h want 1 %h", ack0, rdata0, v);
    end
    @(posedge clk); #1;
    req0 = 1;
    acks = 0;
    for (int k = 0; k < 8; k++) begin
      tests++;
      if (ready0 !== (k % 2 == 0) || ack0 !== (k % 2 == 1)) begin
        fails++; $display("FAIL zw_b2b cycle %0d: ready=%b ack=%b want %b %b", k, ready0, ack0, k % 2 == 0, k % 2 == 1);
      end
      if (ack0 === 1'b1) acks++;
      @(posedge clk); #1;
    end
    req0 = 0;
    tests++;
    if (acks !== 4 || rdata0 !== v) begin
      fails++; $display("FAIL zw_b2b_count: acks=%0d rdata=%h want 4 %h", acks, rdata0, v);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_scenario1();
    test_err();
    test_wrap();
    test_random();
    test_back_to_back();
    test_zero_wait();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
